// File: rtl/irq_ctrl_n.sv
// Parametrised interrupt controller: IE/IF/IME registers, trigger edge detect, fixed-priority dispatch.
// Optional macro IRQ_CTRL_SYNC_EN inserts a 2-flop trigger synchroniser ahead of the edge detector.
module irq_ctrl_n #(
  parameter int unsigned NSRC       = 5,
  parameter int unsigned VW         = 16,
  parameter int unsigned VEC_BASE   = 32'h40,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic [NSRC-1:0] TRIG,
  input  logic [NSRC-1:0] WD,
  input  logic            IE_WR,
  input  logic            IF_WR,
  output logic [NSRC-1:0] IE_Q,
  output logic [NSRC-1:0] IF_Q,
  input  logic            IME_SET,
  input  logic            IME_CLR,
  output logic            IME_Q,
  output logic            IRQ_REQ,
  output logic            WAKE,
  input  logic            ACK,
  output logic [VW-1:0]   VEC,
  output logic            VEC_VLD,
  output logic [3:0]      IDX
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DISP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NSRC-1:0] ie_q, ie_d;
  logic [NSRC-1:0] if_q, if_d;
  logic            ime_q, ime_d;
  logic            irq_req_q, irq_req_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            vec_vld_q, vec_vld_d;
  logic [3:0]      idx_q, idx_d;
  logic [NSRC-1:0] trg_prev_q, trg_prev_d;
  logic [NSRC-1:0] trig_s;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] ack_clr;
  logic [3:0]      lo_idx;
  logic            disp;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync1_d;
  logic [NSRC-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = TRIG;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign trig_s = sync2_q;
`else
  assign trig_s = TRIG;
`endif

  assign rise = trig_s & ~trg_prev_q;
  assign pend = ie_q & if_q;

  // Lowest set pending bit wins; evaluated in the ACK cycle, not when the request was raised.
  always_comb begin
    lo_idx = 4'd0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (pend[i]) lo_idx = 4'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    disp       = 1'b0;
    ack_clr    = '0;
    trg_prev_d = trig_s;
    case (state_q)
      ST_IDLE: if (ime_q && (pend != '0)) state_d = ST_REQ;
      ST_REQ: begin
        if (!ime_q || (pend == '0)) begin
          state_d = ST_IDLE;
        end else if (ACK) begin
          disp    = 1'b1;
          ack_clr = NSRC'(1) << lo_idx;
          state_d = ST_DISP;
        end
      end
      ST_DISP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A trigger edge always wins over a write or an acknowledge clear of the same bit.
    ie_d      = IE_WR ? WD : ie_q;
    if_d      = ((IF_WR ? WD : if_q) & ~ack_clr) | rise;
    ime_d     = (ime_q | IME_SET) & ~IME_CLR & ~disp;
    irq_req_d = (state_d == ST_REQ);
    vec_vld_d = disp;
    idx_d     = disp ? lo_idx : idx_q;
    vec_d     = disp ? VW'(VEC_BASE + 32'(lo_idx) * VEC_STRIDE) : vec_q;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q    <= ST_IDLE;
      ie_q       <= '0;
      if_q       <= '0;
      ime_q      <= 1'b0;
      irq_req_q  <= 1'b0;
      vec_q      <= '0;
      vec_vld_q  <= 1'b0;
      idx_q      <= 4'd0;
      trg_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      if_q       <= if_d;
      ime_q      <= ime_d;
      irq_req_q  <= irq_req_d;
      vec_q      <= vec_d;
      vec_vld_q  <= vec_vld_d;
      idx_q      <= idx_d;
      trg_prev_q <= trg_prev_d;
    end
  end

  assign IE_Q    = ie_q;
  assign IF_Q    = if_q;
  assign IME_Q   = ime_q;
  assign IRQ_REQ = irq_req_q;
  assign VEC     = vec_q;
  assign VEC_VLD = vec_vld_q;
  assign IDX     = idx_q;
  assign WAKE    = |pend;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Directed bench for irq_ctrl_n with default parameters (NSRC=5, VW=16, base 'h40, stride 8).
module tb_irq_ctrl_n;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk, res;
  logic [4:0]  trig, wd;
  logic        ie_wr, if_wr, ime_set, ime_clr, ack;
  logic [4:0]  ie_o, if_o;
  logic        ime_o, irq_req, wake, vec_vld;
  logic [15:0] vec;
  logic [3:0]  idx;

  int total = 0;
  int bad   = 0;

  irq_ctrl_n dut (
    .CLK(clk), .RES(res), .TRIG(trig), .WD(wd), .IE_WR(ie_wr), .IF_WR(if_wr),
    .IE_Q(ie_o), .IF_Q(if_o), .IME_SET(ime_set), .IME_CLR(ime_clr), .IME_Q(ime_o),
    .IRQ_REQ(irq_req), .WAKE(wake), .ACK(ack), .VEC(vec), .VEC_VLD(vec_vld), .IDX(idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    ie_wr = 0; if_wr = 0; ime_set = 0; ime_clr = 0; ack = 0;
  endtask

  task automatic test_reset();
    res = 1; trig = '0; wd = '0; clr_strobes();
    step(); step();
    total++;
    if ({ie_o, if_o, ime_o, irq_req, vec_vld, idx, wake} !== 18'd0 || vec !== 16'd0) begin
      bad++;
      $display("FAIL reset: ie=%b if=%b ime=%b req=%b vld=%b idx=%0d vec=%h wake=%b expected all 0",
               ie_o, if_o, ime_o, irq_req, vec_vld, idx, vec, wake);
    end
    res = 0;
    step();
  endtask

  task automatic test_trigger();
    ie_wr = 1; wd = 5'b00101; ime_set = 1;
    step(); clr_strobes();
    total++;
    if (ie_o !== 5'b00101 || ime_o !== 1'b1) begin
      bad++; $display("FAIL ie_ime_load: ie=%b ime=%b expected 00101 1", ie_o, ime_o);
    end
    trig = 5'b00100;
    for (int k = 0; k < LAT - 1; k++) begin
      step();
      total++;
      if (if_o !== 5'b00000) begin
        bad++; $display("FAIL trig_latency: if=%b expected 00000 at cycle %0d", if_o, k + 1);
      end
    end
    step();
    total++;
    if (if_o !== 5'b00100 || irq_req !== 1'b0) begin
      bad++; $display("FAIL trig_set: if=%b req=%b expected 00100 0", if_o, irq_req);
    end
    step();
    total++;
    if (irq_req !== 1'b1) begin
      bad++; $display("FAIL req_raise: req=%b expected 1", irq_req);
    end
  endtask

  task automatic test_priority_at_ack();
    trig = 5'b00101;
    for (int k = 0; k < LAT; k++) step();
    total++;
    if (if_o !== 5'b00101 || irq_req !== 1'b1) begin
      bad++; $display("FAIL prio_pending: if=%b req=%b expected 00101 1", if_o, irq_req);
    end
    ack = 1;
    step(); ack = 0;
    total++;
    if (idx !== 4'd0 || vec !== 16'h0040 || vec_vld !== 1'b1 || if_o !== 5'b00100 || ime_o !== 1'b0) begin
      bad++; $display("FAIL prio_dispatch: idx=%0d vec=%h vld=%b if=%b ime=%b expected 0 0040 1 00100 0",
                      idx, vec, vec_vld, if_o, ime_o);
    end
    step();
    total++;
    if (vec_vld !== 1'b0 || vec !== 16'h0040 || irq_req !== 1'b0 || wake !== 1'b1) begin
      bad++; $display("FAIL prio_after: vld=%b vec=%h req=%b wake=%b expected 0 0040 0 1",
                      vec_vld, vec, irq_req, wake);
    end
  endtask

  task automatic test_vec_idx4();
    ie_wr = 1; if_wr = 1; wd = 5'b10000; ime_set = 1;
    step(); clr_strobes();
    total++;
    if (irq_req !== 1'b0 || if_o !== 5'b10000) begin
      bad++; $display("FAIL idx4_setup: req=%b if=%b expected 0 10000", irq_req, if_o);
    end
    step();
    total++;
    if (irq_req !== 1'b1) begin
      bad++; $display("FAIL idx4_req: req=%b expected 1", irq_req);
    end
    ack = 1;
    step(); ack = 0;
    total++;
    if (vec !== 16'h0060 || idx !== 4'd4 || vec_vld !== 1'b1 || irq_req !== 1'b0 || if_o !== 5'b00000) begin
      bad++; $display("FAIL idx4_dispatch: vec=%h idx=%0d vld=%b req=%b if=%b expected 0060 4 1 0 00000",
                      vec, idx, vec_vld, irq_req, if_o);
    end
    step();
    total++;
    if (vec_vld !== 1'b0 || irq_req !== 1'b0) begin
      bad++; $display("FAIL idx4_pulse: vld=%b req=%b expected 0 0", vec_vld, irq_req);
    end
  endtask

  task automatic test_ack_outside();
    ie_wr = 1; if_wr = 1; wd = 5'b11111;
    step(); clr_strobes();
    if_wr = 1; wd = 5'b00010;
    step(); clr_strobes();
    ack = 1;
    step(); ack = 0;
    total++;
    if (vec_vld !== 1'b0 || if_o !== 5'b00010 || idx !== 4'd4 || irq_req !== 1'b0) begin
      bad++; $display("FAIL ack_idle: vld=%b if=%b idx=%0d req=%b expected 0 00010 4 0",
                      vec_vld, if_o, idx, irq_req);
    end
  endtask

  task automatic test_set_priority();
    ie_wr = 1; wd = 5'b00000;
    step(); clr_strobes();
    ime_set = 1;
    step(); clr_strobes();
    ime_set = 1; ime_clr = 1;
    step(); clr_strobes();
    total++;
    if (ime_o !== 1'b0) begin
      bad++; $display("FAIL ime_clr_wins: ime=%b expected 0", ime_o);
    end
    trig = 5'b00111;
    for (int k = 0; k < LAT - 1; k++) step();
    if_wr = 1; wd = 5'b00000;
    step(); clr_strobes();
    total++;
    if (if_o !== 5'b00010 || irq_req !== 1'b0) begin
      bad++; $display("FAIL rise_beats_write: if=%b req=%b expected 00010 0", if_o, irq_req);
    end
  endtask

  task automatic test_wake_withdraw();
    ie_wr = 1; if_wr = 1; wd = 5'b01000;
    step(); clr_strobes();
    total++;
    if (wake !== 1'b1 || ime_o !== 1'b0) begin
      bad++; $display("FAIL wake: wake=%b ime=%b expected 1 0", wake, ime_o);
    end
    step();
    total++;
    if (irq_req !== 1'b0) begin
      bad++; $display("FAIL no_req_ime0: req=%b expected 0", irq_req);
    end
    ime_set = 1;
    step(); clr_strobes();
    step();
    total++;
    if (irq_req !== 1'b1) begin
      bad++; $display("FAIL wd_req: req=%b expected 1", irq_req);
    end
    ime_clr = 1;
    step(); clr_strobes();
    total++;
    if (ime_o !== 1'b0 || irq_req !== 1'b1) begin
      bad++; $display("FAIL wd_imeclr: ime=%b req=%b expected 0 1", ime_o, irq_req);
    end
    step();
    total++;
    if (irq_req !== 1'b0 || vec_vld !== 1'b0) begin
      bad++; $display("FAIL wd_drop: req=%b vld=%b expected 0 0", irq_req, vec_vld);
    end
    ack = 1;
    step(); ack = 0;
    total++;
    if (vec_vld !== 1'b0 || if_o !== 5'b01000 || vec !== 16'h0060) begin
      bad++; $display("FAIL wd_ack: vld=%b if=%b vec=%h expected 0 01000 0060", vec_vld, if_o, vec);
    end
  endtask

  task automatic test_ack_race();
    ime_set = 1;
    step(); clr_strobes();
    step();
    total++;
    if (irq_req !== 1'b1) begin
      bad++; $display("FAIL race_req: req=%b expected 1", irq_req);
    end
    if_wr = 1; wd = 5'b00000;
    step(); clr_strobes();
    ack = 1;
    step(); ack = 0;
    total++;
    if (vec_vld !== 1'b0 || irq_req !== 1'b0 || ime_o !== 1'b1 || if_o !== 5'b00000) begin
      bad++; $display("FAIL race_ack: vld=%b req=%b ime=%b if=%b expected 0 0 1 00000",
                      vec_vld, irq_req, ime_o, if_o);
    end
  endtask

  task automatic test_reset_in_disp();
    ie_wr = 1; if_wr = 1; wd = 5'b00001;
    step(); clr_strobes();
    step();
    ack = 1;
    step(); ack = 0;
    total++;
    if (vec_vld !== 1'b1 || idx !== 4'd0 || vec !== 16'h0040) begin
      bad++; $display("FAIL disp_entry: vld=%b idx=%0d vec=%h expected 1 0 0040", vec_vld, idx, vec);
    end
    res = 1;
    #1;
    total++;
    if ({ie_o, if_o, ime_o, irq_req, vec_vld, idx, wake} !== 18'd0 || vec !== 16'd0) begin
      bad++; $display("FAIL async_reset: ie=%b if=%b ime=%b req=%b vld=%b idx=%0d vec=%h wake=%b expected all 0",
                      ie_o, if_o, ime_o, irq_req, vec_vld, idx, vec, wake);
    end
    step();
    res = 0; trig = '0;
    step();
    total++;
    if (vec_vld !== 1'b0 || irq_req !== 1'b0) begin
      bad++; $display("FAIL post_reset: vld=%b req=%b expected 0 0", vec_vld, irq_req);
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_priority_at_ack();
    test_vec_idx4();
    test_ack_outside();
    test_set_priority();
    test_wake_withdraw();
    test_ack_race();
    test_reset_in_disp();
    test_reset();
    test_trigger();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
